// File: rtl/hazard_control_unit_mips_pkg.sv
// rtl/hazard_control_unit_mips_pkg.sv - shared types and constants for the MIPS hazard controller
package mips_hazard_pkg;

    typedef enum logic {IDLE, BUSY} muldiv_state_t;

    localparam logic [4:0] REG_ZERO               = 5'd0;
    localparam int         MULDIV_LATENCY_DEFAULT = 4;
    localparam int         REM_WIDTH              = 4;

endpackage

// File: rtl/hazard_control_unit_mips_if.sv
// rtl/hazard_control_unit_mips_if.sv - Decode/Execute hazard inputs, pipeline controls and perf counters
interface hazard_control_unit_mips_if #(
  parameter int COUNT_WIDTH = 32
);
  logic [4:0]             addressReadARegisterFile_Decode;
  logic [4:0]             addressReadBRegisterFile_Decode;
  logic                   usesB_Decode;
  logic                   readsHiLo_Decode;
  logic                   isMulDiv_Decode;
  logic                   enableReadDataMemory_Execute;
  logic [4:0]             addressWriteRegisterFile_Execute;
  logic                   startMulDiv_Execute;
  logic                   branchTaken_Execute;
  logic                   stallFetch;
  logic                   stallDecode;
  logic                   flushDecode;
  logic                   flushExecute;
  logic                   mulDivBusy;
  logic [COUNT_WIDTH-1:0] loadUseStallCount;
  logic [COUNT_WIDTH-1:0] mulDivStallCount;
  logic [COUNT_WIDTH-1:0] flushCount;

  modport master (
    output addressReadARegisterFile_Decode, addressReadBRegisterFile_Decode, usesB_Decode,
           readsHiLo_Decode, isMulDiv_Decode, enableReadDataMemory_Execute,
           addressWriteRegisterFile_Execute, startMulDiv_Execute, branchTaken_Execute,
    input  stallFetch, stallDecode, flushDecode, flushExecute, mulDivBusy,
           loadUseStallCount, mulDivStallCount, flushCount
  );

  modport slave (
    input  addressReadARegisterFile_Decode, addressReadBRegisterFile_Decode, usesB_Decode,
           readsHiLo_Decode, isMulDiv_Decode, enableReadDataMemory_Execute,
           addressWriteRegisterFile_Execute, startMulDiv_Execute, branchTaken_Execute,
    output stallFetch, stallDecode, flushDecode, flushExecute, mulDivBusy,
           loadUseStallCount, mulDivStallCount, flushCount
  );
endinterface

// File: rtl/hazard_control_unit_mips_muldiv_timer.sv
// rtl/hazard_control_unit_mips_muldiv_timer.sv - mul/div occupancy FSM with down-counter
module hazard_muldiv_timer
  import mips_hazard_pkg::*;
#(
  parameter int MULDIV_LATENCY = MULDIV_LATENCY_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy
);
  localparam logic [REM_WIDTH-1:0] REM_LOAD = REM_WIDTH'(MULDIV_LATENCY - 1);
  localparam logic [REM_WIDTH-1:0] REM_LAST = REM_WIDTH'(1);

  muldiv_state_t        state_q, state_d;
  logic [REM_WIDTH-1:0] rem_q, rem_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // A start in BUSY reloads the count; it only happens if the stall logic upstream is wrong.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (start) begin
      state_d = BUSY;
      rem_d   = REM_LOAD;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
          rem_d   = '0;
        end
        BUSY: begin
          if (rem_q == REM_LAST) begin
            state_d = IDLE;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - REM_LAST;
          end
        end
        default: begin
          state_d = IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  assign busy = (state_q == BUSY);
endmodule

// File: rtl/hazard_control_unit_mips.sv
// rtl/hazard_control_unit_mips.sv - load-use / mul-div / branch hazard controller for the 5-stage MIPS pipe
// Optional perf counters enabled by HAZARD_PERF_COUNTERS_EN.
module hazard_control_unit_mips
  import mips_hazard_pkg::*;
#(
  parameter int MULDIV_LATENCY = MULDIV_LATENCY_DEFAULT,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  hazard_control_unit_mips_if.slave  hz
);
  logic busy;
  logic load_use;
  logic md_haz;
  logic stall;

  hazard_muldiv_timer #(
    .MULDIV_LATENCY(MULDIV_LATENCY)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .start(hz.startMulDiv_Execute),
    .busy (busy)
  );

  assign load_use = hz.enableReadDataMemory_Execute
                 && (hz.addressWriteRegisterFile_Execute != REG_ZERO)
                 && ((hz.addressReadARegisterFile_Decode == hz.addressWriteRegisterFile_Execute)
                  || (hz.usesB_Decode
                   && (hz.addressReadBRegisterFile_Decode == hz.addressWriteRegisterFile_Execute)));

  assign md_haz = (busy || hz.startMulDiv_Execute) && (hz.readsHiLo_Decode || hz.isMulDiv_Decode);

  // A taken branch makes the Decode instruction wrong-path, so its hazards are moot.
  assign stall = !hz.branchTaken_Execute && (load_use || md_haz);

  assign hz.stallFetch   = stall;
  assign hz.stallDecode  = stall;
  assign hz.flushDecode  = hz.branchTaken_Execute;
  assign hz.flushExecute = hz.branchTaken_Execute || stall;
  assign hz.mulDivBusy   = busy;

`ifdef HAZARD_PERF_COUNTERS_EN
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  logic                   lu_ev, md_ev, fl_ev;
  logic [COUNT_WIDTH-1:0] lu_cnt_q, lu_cnt_d;
  logic [COUNT_WIDTH-1:0] md_cnt_q, md_cnt_d;
  logic [COUNT_WIDTH-1:0] fl_cnt_q, fl_cnt_d;

  assign lu_ev = !hz.branchTaken_Execute && load_use;
  assign md_ev = !hz.branchTaken_Execute && !load_use && md_haz;
  assign fl_ev = hz.branchTaken_Execute;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    lu_cnt_d = lu_cnt_q;
    md_cnt_d = md_cnt_q;
    fl_cnt_d = fl_cnt_q;
    if (lu_ev && (lu_cnt_q != '1)) lu_cnt_d = lu_cnt_q + CNT_ONE;
    if (md_ev && (md_cnt_q != '1)) md_cnt_d = md_cnt_q + CNT_ONE;
    if (fl_ev && (fl_cnt_q != '1)) fl_cnt_d = fl_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lu_cnt_q <= '0;
      md_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      lu_cnt_q <= lu_cnt_d;
      md_cnt_q <= md_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  assign hz.loadUseStallCount = lu_cnt_q;
  assign hz.mulDivStallCount  = md_cnt_q;
  assign hz.flushCount        = fl_cnt_q;
`else
  assign hz.loadUseStallCount = '0;
  assign hz.mulDivStallCount  = '0;
  assign hz.flushCount        = '0;
`endif
endmodule

// File: tb/tb_hazard_control_unit_mips.sv
// tb/tb_hazard_control_unit_mips.sv - scoreboard bench with randomized and directed hazard stimulus
module tb_hazard_control_unit_mips;
  localparam int LAT = 4;
  localparam int CW  = 32;

  typedef struct {
    logic [4:0]  ctl;   // {stallFetch, stallDecode, flushDecode, flushExecute, mulDivBusy}
    longint      lu, md, fl;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_control_unit_mips_if #(.COUNT_WIDTH(CW)) hif ();

  hazard_control_unit_mips #(
    .MULDIV_LATENCY(LAT),
    .COUNT_WIDTH   (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hif.slave)
  );

  exp_t   exp_q[$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     busy_end = -100;
  longint n_lu = 0, n_md = 0, n_fl = 0;

  // Reference: mul/div issued in cycle t occupies cycles t+1 .. t+LAT-1.
  task automatic step(input bit rst, input int ra, input int rb, input bit ub, input bit hilo,
                      input bit md, input bit ld, input int wr, input bit st, input bit br);
    exp_t e;
    bit busy, lu, mh, stl;
    @(posedge clk);
    #1;
    reset = rst;
    hif.addressReadARegisterFile_Decode  = 5'(ra);
    hif.addressReadBRegisterFile_Decode  = 5'(rb);
    hif.usesB_Decode                     = ub;
    hif.readsHiLo_Decode                 = hilo;
    hif.isMulDiv_Decode                  = md;
    hif.enableReadDataMemory_Execute     = ld;
    hif.addressWriteRegisterFile_Execute = 5'(wr);
    hif.startMulDiv_Execute              = st;
    hif.branchTaken_Execute              = br;
    cyc++;
    if (rst) begin
      busy_end = -100;
      n_lu = 0; n_md = 0; n_fl = 0;
    end
    busy = !rst && (cyc <= busy_end);
    lu   = ld && (wr != 0) && (ra == wr || (ub && rb == wr));
    mh   = (busy || st) && (hilo || md);
    stl  = !br && (lu || mh);
    e.ctl = {stl, stl, br, br || stl, busy};
    e.cyc = cyc;
`ifdef HAZARD_PERF_COUNTERS_EN
    e.lu = n_lu; e.md = n_md; e.fl = n_fl;
    if (!rst) begin
      if (!br && lu) n_lu++;
      else if (!br && mh) n_md++;
      if (br) n_fl++;
    end
`else
    e.lu = 0; e.md = 0; e.fl = 0;
`endif
    if (!rst && st) busy_end = cyc + LAT - 1;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [4:0] act;
      e = exp_q.pop_front();
      act = {hif.stallFetch, hif.stallDecode, hif.flushDecode, hif.flushExecute, hif.mulDivBusy};
      total++;
      if (act !== e.ctl) begin
        bad++;
        $display("FAIL ctl cyc=%0d got=%b want=%b (sF sD fD fE busy)", e.cyc, act, e.ctl);
      end
      total++;
      if (hif.loadUseStallCount !== CW'(e.lu) || hif.mulDivStallCount !== CW'(e.md)
          || hif.flushCount !== CW'(e.fl)) begin
        bad++;
        $display("FAIL cnt cyc=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", e.cyc,
                 hif.loadUseStallCount, hif.mulDivStallCount, hif.flushCount, e.lu, e.md, e.fl);
      end
    end
  end

  initial begin
    hif.addressReadARegisterFile_Decode  = '0;
    hif.addressReadBRegisterFile_Decode  = '0;
    hif.usesB_Decode                     = 1'b0;
    hif.readsHiLo_Decode                 = 1'b0;
    hif.isMulDiv_Decode                  = 1'b0;
    hif.enableReadDataMemory_Execute     = 1'b0;
    hif.addressWriteRegisterFile_Execute = '0;
    hif.startMulDiv_Execute              = 1'b0;
    hif.branchTaken_Execute              = 1'b0;

    // reset, then first cycle after release
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // load-use on rs, bubble in Execute next cycle
    step(0, 5, 1, 0, 0, 0, 1, 5, 0, 0);
    step(0, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    // $0 never hazards; rt match without usesB is no hazard; rt match with usesB is
    step(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    step(0, 1, 7, 0, 0, 0, 1, 7, 0, 0);
    step(0, 1, 7, 1, 0, 0, 1, 7, 0, 0);

    // mul/div issue, MFLO waits until busy falls
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // branch beats a simultaneous load-use
    step(0, 3, 0, 0, 0, 0, 1, 3, 0, 1);
    idle(1);

    // back-to-back mul/div: second MULT stalls, then issues and reloads
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < LAT - 1; i++) step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < LAT - 1; i++) step(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    idle(1);

    // reset asserted mid-BUSY clears busy immediately; MFHI afterwards proceeds
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0),
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 2) == 0), $urandom_range(0, 3),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_control_unit_mips.md
Name: hazard_control_unit_mips

Overview:
- Pipeline hazard controller for the 5-stage MIPS core. It sits beside the data forwarding unit and handles the cases forwarding cannot resolve.
- Load-use hazard: inserts one bubble.
- Multi-cycle multiply/divide: tracks occupancy and stalls HI/LO consumers and any new mul/div.
- Taken branch: flushes the wrong-path instructions.
- Drives stall/flush controls for the IF/ID and ID/EX pipeline registers.

Parameters:
- MULDIV_LATENCY, 4: cycles the mul/div unit is busy after issue from Execute. Legal range 2..15.
- COUNT_WIDTH, 32: width of the performance counters.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- addressReadARegisterFile_Decode  in  5  rs of the instruction in Decode
- addressReadBRegisterFile_Decode  in  5  rt of the instruction in Decode
- usesB_Decode  in  1  Decode instruction reads rt as an ALU source
- readsHiLo_Decode  in  1  Decode instruction is MFHI or MFLO
- isMulDiv_Decode  in  1  Decode instruction is MULT, MULTU, DIV or DIVU
- enableReadDataMemory_Execute  in  1  Execute instruction is a load
- addressWriteRegisterFile_Execute  in  5  destination register of the Execute instruction
- startMulDiv_Execute  in  1  a mul/div is issuing from Execute this cycle
- branchTaken_Execute  in  1  branch/jump in Execute resolved taken
- stallFetch  out  1  hold PC and IF/ID
- stallDecode  out  1  hold IF/ID contents
- flushDecode  out  1  clear IF/ID to NOP
- flushExecute  out  1  load a bubble into ID/EX
- mulDivBusy  out  1  mul/div unit occupied
- loadUseStallCount  out  COUNT_WIDTH  performance counter
- mulDivStallCount  out  COUNT_WIDTH  performance counter
- flushCount  out  COUNT_WIDTH  performance counter

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE and the busy counter goes to 0.
  - All outputs are 0 while reset is asserted and in the first cycle after release, unless inputs assert a combinational hazard in that cycle.
- FSM states:
  - IDLE: mul/div unit free.
  - BUSY: remCycles > 0.
- FSM transitions:
  - IDLE -> BUSY when startMulDiv_Execute=1; remCycles loads MULDIV_LATENCY-1.
  - In BUSY, remCycles decrements each cycle. BUSY -> IDLE in the cycle after remCycles reaches 1, so mulDivBusy is high for exactly MULDIV_LATENCY-1 cycles after the issue cycle.
  - startMulDiv_Execute while in BUSY reloads the counter. This is defensive; it cannot occur with a correct stall.
- mulDivBusy = (state==BUSY). Registered.
- Hazard terms (combinational, same cycle):
  - loadUse = enableReadDataMemory_Execute && addressWriteRegisterFile_Execute!=0 && (addressReadARegisterFile_Decode==addressWriteRegisterFile_Execute || (usesB_Decode && addressReadBRegisterFile_Decode==addressWriteRegisterFile_Execute))
  - mdHaz = (mulDivBusy || startMulDiv_Execute) && (readsHiLo_Decode || isMulDiv_Decode)
- Priority: branch > loadUse > mdHaz.
  - branchTaken_Execute=1: flushDecode=1, flushExecute=1, stallFetch=0, stallDecode=0. Any loadUse or mdHaz in the same cycle is discarded because the Decode instruction is wrong-path.
  - Otherwise, loadUse or mdHaz: stallFetch=1, stallDecode=1, flushExecute=1, flushDecode=0.
  - Otherwise: all four controls are 0.
- Load-use inserts exactly one bubble. The next cycle has the bubble in Execute, so loadUse deasserts. MEM->EX forwarding then supplies the operand.
- mdHaz stalls until mulDivBusy falls. The HI/LO consumer proceeds in the first cycle with mulDivBusy=0 and startMulDiv_Execute=0.
- A taken branch while BUSY does not cancel the mul/div; the counter keeps running.
- Register 0 never creates a load-use hazard.

Optional Feature:
- Macro: HAZARD_PERF_COUNTERS_EN.
- Defined:
  - The three counters are COUNT_WIDTH-bit, reset to 0, and saturate at all-ones.
  - loadUseStallCount increments on cycles where the load-use stall is applied.
  - mulDivStallCount increments on mdHaz stall cycles.
  - flushCount increments on branch flush cycles.
- Undefined:
  - The counters are tied to 0 and no counter flops exist.

Decomposition:
- Package mips_hazard_pkg holds:
  - typedef enum logic {IDLE, BUSY} muldiv_state_t
  - localparam REG_ZERO = 5'd0
  - the default MULDIV_LATENCY constant
- Sub-module hazard_muldiv_timer holds the FSM and down-counter.
  - Inputs: clk, reset, start.
  - Output: busy.
- The top level keeps the hazard compare, the priority mux and the counters.

Test Plan:
- Load-use on rs: load writing $5 in Execute, Decode reads rs=$5 -> stallFetch/stallDecode/flushExecute=1 for exactly 1 cycle, then 0. Perf-counter build: loadUseStallCount=1.
- No hazard cases:
  - addressWriteRegisterFile_Execute=0, Decode rs=0, load in Execute -> no stall.
  - rt match with usesB_Decode=0 -> no stall.
- MULDIV_LATENCY=4: startMulDiv_Execute at cycle 0, MFLO in Decode at cycle 1 -> mulDivBusy=1 for cycles 1-3, stall held for cycles 1-3, MFLO proceeds at cycle 4. Perf-counter build: mulDivStallCount=3.
- Branch priority: branchTaken_Execute=1 and load-use both true in the same cycle -> flushDecode=flushExecute=1, stallFetch=0. Perf-counter build: loadUseStallCount unchanged, flushCount+1.
- Reset mid-operation: reset asserted at cycle 2 of BUSY -> mulDivBusy=0 immediately (async). After release, MFHI in Decode proceeds with no stall.
- Back-to-back mul/div: MULT in Decode while BUSY -> stalled until mulDivBusy falls, then issues and the counter reloads to 3.
